uart_tx_queue: RTL

Byte queue that sits directly upstream of the UART transmitter and drives its tx_start/tx_data/tx_busy handshake. A host writes bytes at full clock rate into a DEPTH-entry circular FIFO. The block launches one UART frame per byte, in order, waiting for each frame to complete before starting the next. This lets bursts of bytes be sent back-to-back without the host polling tx_busy.

---
 rtl/uart_tx_queue_if.sv | 54 +++++
 rtl/uart_tx_queue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue_if.sv
// ----------------------------------------------------------------------------
// uart_tx_queue_if
// Groups the host write port and the UART launch handshake of uart_tx_queue.
//
// Signals:
//   wr_en, wr_data      host -> queue   one byte per cycle when wr_en=1
//   full, empty, count  queue -> host   occupancy (count excludes the byte in flight)
//   overflow            queue -> host   sticky, a write was attempted while full
//   tx_start, tx_data   queue -> UART   one-cycle launch pulse and frame byte
//   tx_busy             UART -> queue   frame in progress
//   flush, err_cnt      only when UART_TXQ_FLUSH_EN is defined
//
// Modports:
//   slave  - the queue itself
//   master - the environment (host plus UART) around it
// DEPTH must match the DEPTH of the uart_tx_queue instance bound to it.
// ----------------------------------------------------------------------------
interface uart_tx_queue_if #(
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
`ifdef UART_TXQ_FLUSH_EN
    logic          flush;
    logic [7:0]    err_cnt;
`endif

    modport slave (
        input  wr_en, wr_data, tx_busy,
`ifdef UART_TXQ_FLUSH_EN
        input  flush,
        output err_cnt,
`endif
        output full, empty, count, overflow, tx_start, tx_data
    );

    modport master (
        output wr_en, wr_data, tx_busy,
`ifdef UART_TXQ_FLUSH_EN
        output flush,
        input  err_cnt,
`endif
        input  full, empty, count, overflow, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_queue.sv
// ----------------------------------------------------------------------------
// uart_tx_queue
// Byte FIFO in front of a UART transmitter. The host writes bytes at full clock
// rate; the queue launches one UART frame per byte, in order, and waits for
// each frame to finish (tx_busy low) before launching the next.
//
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous, active-high reset; queued bytes are discarded
//   txq_io  uart_tx_queue_if.slave (host write port + UART handshake)
//
// Parameters:
//   DEPTH   FIFO entries, power of two, >= 2
//
// Build option:
//   UART_TXQ_FLUSH_EN  adds flush input (drop every queued byte, clear
//                      overflow) and err_cnt output (saturating count of
//                      launches the UART never acknowledged).
// ----------------------------------------------------------------------------
module uart_tx_queue #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_queue_if.slave txq_io
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    // Cycles WAIT_BUSY waits for tx_busy before giving the byte up.
    localparam logic [1:0]    WAIT_LAST = 2'd2;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;

    state_e        state_q;
    logic [1:0]    wait_cnt_q;
    logic          tx_start_q;
    logic [7:0]    tx_data_q;
`ifdef UART_TXQ_FLUSH_EN
    logic [7:0]    err_cnt_q;
`endif

    logic full, empty, push, pop, flush_req;

    // ------------------------------------------------------------------
    // Occupancy and next-state pointer logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
        full       = (count_q == CNT_FULL);
        empty      = (count_q == '0);
`ifdef UART_TXQ_FLUSH_EN
        flush_req  = txq_io.flush;
`else
        flush_req  = 1'b0;
`endif
        // A pop only happens when the FSM is idle and the UART is free.
        pop        = (state_q == IDLE) && !empty && !txq_io.tx_busy;
        // 'full' is the pre-pop count, so a full FIFO refuses a write even on a pop cycle.
        push       = txq_io.wr_en && !full && !flush_req;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (txq_io.wr_en & full);

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Flush empties the queue but leaves any byte already handed to the FSM alone.
        if (flush_req) begin
            rd_ptr_d   = wr_ptr_q;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: the data array has no reset; pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= txq_io.wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Launch FSM with registered tx_start / tx_data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
`ifdef UART_TXQ_FLUSH_EN
            err_cnt_q  <= 8'h00;
`endif
        end else begin
            // Launch pulse is exactly one cycle wide.
            tx_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_data_q  <= mem_q[rd_ptr_q];
                        tx_start_q <= 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (txq_io.tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        // UART never acknowledged: drop this byte and move on.
                        state_q <= IDLE;
`ifdef UART_TXQ_FLUSH_EN
                        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
`endif
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!txq_io.tx_busy) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign txq_io.full     = full;
    assign txq_io.empty    = empty;
    assign txq_io.count    = count_q;
    assign txq_io.overflow = overflow_q;
    assign txq_io.tx_start = tx_start_q;
    assign txq_io.tx_data  = tx_data_q;
`ifdef UART_TXQ_FLUSH_EN
    assign txq_io.err_cnt  = err_cnt_q;
`endif

endmodule
